dut_stim_checker: RTL and testbench

Bench-side counterpart of the overclocking test DUT. It drives the DUT's two 16-bit operand inputs with a pseudo-random stream and checks the DUT's registered 32-bit result against the expected concatenation `{B, A}`. It also counts mismatches. The block sits in the same clock domain as the DUT and reports pass/fail and error statistics to the bench controller.

---
 rtl/dut_stim_checker_if.sv | 48 ++++
 rtl/dut_stim_checker.sv | 183 ++++++++++++++++++
 tb/tb_dut_stim_checker.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dut_stim_checker_if.sv
// ---------------------------------------------------------------------------
// dut_stim_checker_if
//
// Groups every non-clock signal of the stimulus/checker block into one
// bundle. The checker owns the master modport; whoever sits on the other side
// (bench controller plus the DUT under overclocking test) uses the slave
// modport.
//
// Signals:
//   START          controller -> checker  one-cycle run launch pulse
//   N_TESTS        controller -> checker  vector count for the run
//   SEED           controller -> checker  LFSR seed (0 is mapped to 1)
//   A_OUT, B_OUT   checker -> DUT         16-bit operands, registered
//   DUT_OUT        DUT -> checker         32-bit result, expected {B, A}
//   BUSY           checker -> controller  run or drain in progress
//   DONE           checker -> controller  run finished, results held
//   PASS           checker -> controller  DONE with zero mismatches
//   ERR_CNT        checker -> controller  saturating mismatch count
//   FIRST_ERR_IDX  checker -> controller  index of first mismatch, all-ones if none
// ---------------------------------------------------------------------------
interface dut_stim_checker_if #(
    parameter int CNT_W = 32
);
    logic             START;
    logic [CNT_W-1:0] N_TESTS;
    logic [31:0]      SEED;
    logic [15:0]      A_OUT;
    logic [15:0]      B_OUT;
    logic [31:0]      DUT_OUT;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [CNT_W-1:0] ERR_CNT;
    logic [CNT_W-1:0] FIRST_ERR_IDX;

    // The checker drives the operands and the status, and receives the
    // controls and the DUT result.
    modport master (
        input  START, N_TESTS, SEED, DUT_OUT,
        output A_OUT, B_OUT, BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_IDX
    );

    // The controller/DUT side is the mirror image.
    modport slave (
        output START, N_TESTS, SEED, DUT_OUT,
        input  A_OUT, B_OUT, BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_IDX
    );
endinterface

// File: rtl/dut_stim_checker.sv
// ---------------------------------------------------------------------------
// dut_stim_checker
//
// Stimulus generator and result checker for the overclocking test DUT. On a
// START pulse it streams N_TESTS pseudo-random 32-bit vectors (Galois LFSR)
// onto A_OUT/B_OUT, one per cycle, and compares DUT_OUT against {B, A} exactly
// LATENCY cycles after each vector is presented. Mismatches are counted
// (saturating) and the index of the first one is captured.
//
// Parameters:
//   LATENCY  cycles from a vector on A_OUT/B_OUT to its result on DUT_OUT (>= 1)
//   CNT_W    width of the vector index and error counters
//
// Ports:
//   CLK      clock, shared with the DUT
//   RST      synchronous, active-high reset
//   bus      dut_stim_checker_if master modport (controls, operands, status)
// ---------------------------------------------------------------------------
module dut_stim_checker #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    dut_stim_checker_if.master bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Galois LFSR step, shifting right with tap mask 0x8020_0003.
    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    state_e           state_q,    state_d;
    logic [31:0]      lfsr_q,     lfsr_d;
    logic [CNT_W-1:0] idx_q,      idx_d;
    logic [CNT_W-1:0] nTests_q,   nTests_d;
    logic [15:0]      a_q,        a_d;
    logic [15:0]      b_q,        b_d;
    logic             issValid_q, issValid_d;
    logic [CNT_W-1:0] issIdx_q,   issIdx_d;
    logic [CNT_W-1:0] errCnt_q,   errCnt_d;
    logic [CNT_W-1:0] firstErr_q, firstErr_d;

    // Delay line between the operand register and the compare point. Stage 0
    // is fed from the operand register, so together with that register the
    // result is examined at the end of the LATENCY-th cycle after the vector
    // appeared on A_OUT/B_OUT.
    logic             stValid_q [LATENCY];
    logic [31:0]      stExp_q   [LATENCY];
    logic [CNT_W-1:0] stIdx_q   [LATENCY];

    logic             inFlight;
    logic             mismatch;

    // Anything still travelling towards the compare point other than the
    // entry being compared right now. When this is clear during DRAIN, the
    // final comparison happens on this edge and DONE follows it.
    always_comb begin
        inFlight = issValid_q;
        for (int j = 0; j < LATENCY - 1; j++) begin
            inFlight = inFlight | stValid_q[j];
        end
    end

    // Only slots that carry an issued vector are ever compared.
    always_comb begin
        mismatch = stValid_q[LATENCY-1] && (bus.DUT_OUT != stExp_q[LATENCY-1]);
    end

    // Next-state logic: error bookkeeping first, then state-specific updates.
    // A new START overrides the bookkeeping because it clears the counters.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        idx_d      = idx_q;
        nTests_d   = nTests_q;
        a_d        = a_q;
        b_d        = b_q;
        issValid_d = 1'b0;
        issIdx_d   = issIdx_q;
        errCnt_d   = errCnt_q;
        firstErr_d = firstErr_q;

        if (mismatch) begin
            if (errCnt_q != CNT_ONES) begin
                errCnt_d = errCnt_q + CNT_ONE;
            end
            if (firstErr_q == CNT_ONES) begin
                firstErr_d = stIdx_q[LATENCY-1];
            end
        end

        case (state_q)
            StIdle, StDone: begin
                if (bus.START) begin
                    lfsr_d     = (bus.SEED == 32'h0) ? 32'h0000_0001 : bus.SEED;
                    idx_d      = '0;
                    nTests_d   = bus.N_TESTS;
                    errCnt_d   = '0;
                    firstErr_d = CNT_ONES;
                    state_d    = (bus.N_TESTS == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                {b_d, a_d} = lfsr_q;
                issValid_d = 1'b1;
                issIdx_d   = idx_q;
                lfsr_d     = lfsrStep(lfsr_q);
                idx_d      = idx_q + CNT_ONE;
                if (idx_q + CNT_ONE == nTests_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!inFlight) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register plus delay line. Reset throws away any run in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            lfsr_q     <= 32'h0000_0001;
            idx_q      <= '0;
            nTests_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            issValid_q <= 1'b0;
            issIdx_q   <= '0;
            errCnt_q   <= '0;
            firstErr_q <= CNT_ONES;
            for (int j = 0; j < LATENCY; j++) begin
                stValid_q[j] <= 1'b0;
                stExp_q[j]   <= '0;
                stIdx_q[j]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            nTests_q   <= nTests_d;
            a_q        <= a_d;
            b_q        <= b_d;
            issValid_q <= issValid_d;
            issIdx_q   <= issIdx_d;
            errCnt_q   <= errCnt_d;
            firstErr_q <= firstErr_d;
            stValid_q[0] <= issValid_q;
            stExp_q[0]   <= {b_q, a_q};
            stIdx_q[0]   <= issIdx_q;
            for (int j = 1; j < LATENCY; j++) begin
                stValid_q[j] <= stValid_q[j-1];
                stExp_q[j]   <= stExp_q[j-1];
                stIdx_q[j]   <= stIdx_q[j-1];
            end
        end
    end

    assign bus.A_OUT         = a_q;
    assign bus.B_OUT         = b_q;
    assign bus.BUSY          = (state_q == StRun) || (state_q == StDrain);
    assign bus.DONE          = (state_q == StDone);
    assign bus.PASS          = (state_q == StDone) && (errCnt_q == '0);
    assign bus.ERR_CNT       = errCnt_q;
    assign bus.FIRST_ERR_IDX = firstErr_q;

endmodule

// File: tb/tb_dut_stim_checker.sv
// ---------------------------------------------------------------------------
// tb_dut_stim_checker
//
// Drives dut_stim_checker against a behavioural model of the overclocking
// DUT (registered inputs, registered output, result {b, a}). The model can
// flip bit 0 of one chosen result or add an extra cycle of latency so that
// the checker's error reporting is exercised as well as the clean path.
// ---------------------------------------------------------------------------
module tb_dut_stim_checker;

    localparam logic [63:0] ALL_ONES = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    dut_stim_checker_if #(.CNT_W(32)) bus ();

    dut_stim_checker #(
        .LATENCY(2),
        .CNT_W  (32)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // DUT model: two register stages, optionally a third, optionally
    // corrupting the result whose value equals flipVal.
    logic [31:0] r1 = '0, r2 = '0, r3 = '0;
    logic        useLat3 = 1'b0;
    logic        flipEn  = 1'b0;
    logic [31:0] flipVal = '0;

    always @(posedge clk) begin
        r1 <= {bus.B_OUT, bus.A_OUT};
        r2 <= r1;
        r3 <= r2;
    end

    assign bus.DUT_OUT = useLat3 ? r3 :
                         ((flipEn && r2 == flipVal) ? (r2 ^ 32'h1) : r2);

    function automatic logic [31:0] lfsrNext(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] lfsrNth(input logic [31:0] seed, input int n);
        logic [31:0] s;
        s = seed;
        for (int i = 0; i < n; i++) s = lfsrNext(s);
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse START for one edge; returns #1 after that edge (edge k).
    task automatic applyStimulus(input logic [31:0] seed, input logic [31:0] n);
        bus.START   = 1'b1;
        bus.SEED    = seed;
        bus.N_TESTS = n;
        @(posedge clk); #1;
        bus.START   = 1'b0;
    endtask

    // Count edges until DONE, starting from the given count; bounded.
    task automatic waitDone(input int startCyc, output int cyc);
        cyc = startCyc;
        while (!bus.DONE && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_A"},     64'(bus.A_OUT), 64'h0);
        checkOutput({tag, "_B"},     64'(bus.B_OUT), 64'h0);
        checkOutput({tag, "_BUSY"},  64'(bus.BUSY), 64'h0);
        checkOutput({tag, "_DONE"},  64'(bus.DONE), 64'h0);
        checkOutput({tag, "_PASS"},  64'(bus.PASS), 64'h0);
        checkOutput({tag, "_ERR"},   64'(bus.ERR_CNT), 64'h0);
        checkOutput({tag, "_FIRST"}, 64'(bus.FIRST_ERR_IDX), ALL_ONES);
    endtask

    initial begin
        int cyc;
        int expErr;
        logic [31:0] s, prev;

        bus.START   = 1'b0;
        bus.SEED    = '0;
        bus.N_TESTS = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkResetValues("rst");

        // Ideal model, seed 0x12345678, 100 vectors.
        applyStimulus(32'h1234_5678, 100);
        checkOutput("ideal_busy", 64'(bus.BUSY), 64'h1);
        @(posedge clk); #1;
        checkOutput("ideal_firstA", 64'(bus.A_OUT), 64'h5678);
        checkOutput("ideal_firstB", 64'(bus.B_OUT), 64'h1234);
        waitDone(1, cyc);
        checkOutput("ideal_lat",   64'(cyc), 64'd103);
        checkOutput("ideal_pass",  64'(bus.PASS), 64'h1);
        checkOutput("ideal_err",   64'(bus.ERR_CNT), 64'h0);
        checkOutput("ideal_first", 64'(bus.FIRST_ERR_IDX), ALL_ONES);
        checkOutput("ideal_busyLow", 64'(bus.BUSY), 64'h0);
        checkOutput("ideal_hold", 64'({bus.B_OUT, bus.A_OUT}),
                    64'(lfsrNth(32'h1234_5678, 99)));

        // Single corrupted result at vector 37.
        flipVal = lfsrNth(32'h1234_5678, 37);
        flipEn  = 1'b1;
        applyStimulus(32'h1234_5678, 100);
        waitDone(0, cyc);
        flipEn  = 1'b0;
        checkOutput("flip_lat",   64'(cyc), 64'd103);
        checkOutput("flip_err",   64'(bus.ERR_CNT), 64'd1);
        checkOutput("flip_first", 64'(bus.FIRST_ERR_IDX), 64'd37);
        checkOutput("flip_pass",  64'(bus.PASS), 64'h0);

        // Re-START from DONE clears the counters and uses the new seed.
        applyStimulus(32'hCAFE_F00D, 10);
        checkOutput("restart_err",   64'(bus.ERR_CNT), 64'h0);
        checkOutput("restart_first", 64'(bus.FIRST_ERR_IDX), ALL_ONES);
        checkOutput("restart_done",  64'(bus.DONE), 64'h0);
        @(posedge clk); #1;
        checkOutput("restart_vec", 64'({bus.B_OUT, bus.A_OUT}), 64'h0000_0000_CAFE_F00D);
        waitDone(1, cyc);
        checkOutput("restart_lat",  64'(cyc), 64'd13);
        checkOutput("restart_pass", 64'(bus.PASS), 64'h1);

        // START during RUN is ignored: sequence and length unchanged.
        applyStimulus(32'hA5A5_0F0F, 30);
        repeat (5) begin @(posedge clk); #1; end
        applyStimulus(32'h0000_0001, 5);
        checkOutput("midstart_vec", 64'({bus.B_OUT, bus.A_OUT}),
                    64'(lfsrNth(32'hA5A5_0F0F, 5)));
        waitDone(6, cyc);
        checkOutput("midstart_lat",  64'(cyc), 64'd33);
        checkOutput("midstart_pass", 64'(bus.PASS), 64'h1);

        // N_TESTS = 0 straight after reset.
        pulseReset();
        applyStimulus(32'h0000_1234, 0);
        checkOutput("zero_done", 64'(bus.DONE), 64'h1);
        checkOutput("zero_pass", 64'(bus.PASS), 64'h1);
        checkOutput("zero_busy", 64'(bus.BUSY), 64'h0);
        checkOutput("zero_A",    64'(bus.A_OUT), 64'h0);
        checkOutput("zero_B",    64'(bus.B_OUT), 64'h0);

        // SEED = 0 is replaced by 1.
        applyStimulus(32'h0, 4);
        @(posedge clk); #1;
        checkOutput("seed0_A", 64'(bus.A_OUT), 64'h0001);
        checkOutput("seed0_B", 64'(bus.B_OUT), 64'h0000);
        waitDone(1, cyc);
        checkOutput("seed0_lat",  64'(cyc), 64'd7);
        checkOutput("seed0_pass", 64'(bus.PASS), 64'h1);

        // Reset while vector 20 is on the outputs, then a clean run.
        applyStimulus(32'h0BAD_BEEF, 60);
        repeat (21) begin @(posedge clk); #1; end
        checkOutput("abort_vec20", 64'({bus.B_OUT, bus.A_OUT}),
                    64'(lfsrNth(32'h0BAD_BEEF, 20)));
        pulseReset();
        checkResetValues("abort");
        applyStimulus(32'h0BAD_BEEF, 40);
        waitDone(0, cyc);
        checkOutput("abort_rerun_lat",  64'(cyc), 64'd43);
        checkOutput("abort_rerun_pass", 64'(bus.PASS), 64'h1);

        // Model one cycle slower than LATENCY: each vector is compared with
        // its predecessor (zero for vector 0, since A/B were reset).
        pulseReset();
        repeat (4) @(posedge clk);
        #1 useLat3 = 1'b1;
        expErr = 0;
        prev = 32'h0;
        s = 32'h1357_9BDF;
        for (int i = 0; i < 50; i++) begin
            if (s != prev) expErr++;
            prev = s;
            s = lfsrNext(s);
        end
        applyStimulus(32'h1357_9BDF, 50);
        waitDone(0, cyc);
        useLat3 = 1'b0;
        checkOutput("lat3_lat",   64'(cyc), 64'd53);
        checkOutput("lat3_err",   64'(bus.ERR_CNT), 64'(expErr));
        checkOutput("lat3_first", 64'(bus.FIRST_ERR_IDX), 64'h0);
        checkOutput("lat3_pass",  64'(bus.PASS), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
